// File: rtl/fb_pkg.sv
// Shared framebuffer constants and arbiter state type.
package fb_pkg;

    localparam int FB_ADDR_W = 17;
    localparam int FB_DATA_W = 12;
    localparam int FB_DEPTH  = 76800;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } fb_state_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// Small synchronous write buffer holding {address, pixel} entries.
// Head entry is presented combinationally; count is registered.
module fb_wr_fifo #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 12,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty
);
    import fb_pkg::*;

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENT_W = ADDR_W + DATA_W;

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign {head_addr, head_data} = mem[rd_ptr_reg];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage needs no reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= {push_addr, push_data};
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer arbiter: scan-out reads win, buffered writes drain when idle.
// Optional power-up clear sweep enabled by defining FB_CLEAR_EN.
module fb_port_arbiter #(
    parameter int ADDR_W     = fb_pkg::FB_ADDR_W,
    parameter int DATA_W     = fb_pkg::FB_DATA_W,
    parameter int FB_DEPTH   = fb_pkg::FB_DEPTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              wr_drop,
    output logic              busy,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);
    import fb_pkg::*;

    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W+1)'(FB_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

    logic              active_reg;
    logic              rd_valid_reg;
    logic [DATA_W-1:0] rd_hold_reg;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              head_oor;
    logic              clear_mode;
    logic              run_mode;
    logic              rd_honour;
    logic [ADDR_W-1:0] clr_addr;

    // Port stays quiet until the first edge after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) active_reg <= 1'b0;
        else          active_reg <= 1'b1;
    end

    assign wr_ready  = active_reg & ~fifo_full;
    assign fifo_push = wr_valid & wr_ready;
    assign head_oor  = ({1'b0, head_addr} >= DEPTH_LIM);

    fb_wr_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_addr (wr_addr),
        .push_data (wr_data),
        .pop       (fifo_pop),
        .head_addr (head_addr),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef FB_CLEAR_EN
    fb_state_t         state_reg, state_next;
    logic [ADDR_W-1:0] clr_cnt_reg, clr_cnt_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_CLEAR;
            clr_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        if (active_reg && state_reg == ST_CLEAR) begin
            clr_cnt_next = clr_cnt_reg + 1'b1;
            if (clr_cnt_reg == LAST_ADDR) state_next = ST_RUN;
        end
    end

    assign clear_mode = (state_reg == ST_CLEAR);
    assign clr_addr   = clr_cnt_reg;
`else
    assign clear_mode = 1'b0;
    assign clr_addr   = '0;
`endif

    assign busy     = clear_mode;
    assign run_mode = active_reg & ~clear_mode;

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_din   = '0;
        fifo_pop  = 1'b0;
        rd_honour = 1'b0;
        wr_drop   = 1'b0;
        if (active_reg && clear_mode) begin
            ram_we   = 1'b1;
            ram_addr = clr_addr;
        end else if (run_mode) begin
            if (rd_req) begin
                rd_honour = 1'b1;
                ram_addr  = rd_addr;
            end else if (!fifo_empty) begin
                fifo_pop = 1'b1;
                // Out-of-range head is discarded without touching the RAM.
                if (head_oor) begin
                    wr_drop = 1'b1;
                end else begin
                    ram_we   = 1'b1;
                    ram_addr = head_addr;
                    ram_din  = head_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_reg <= 1'b0;
            rd_hold_reg  <= '0;
        end else begin
            rd_valid_reg <= rd_honour;
            if (rd_valid_reg) rd_hold_reg <= ram_dout;
        end
    end

    // RAM output is live during the valid cycle, then held.
    assign rd_valid = rd_valid_reg;
    assign rd_data  = rd_valid_reg ? ram_dout : rd_hold_reg;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Self-checking bench for fb_port_arbiter with a behavioural sync RAM and write scoreboard.
module tb_fb_port_arbiter;

    localparam int AW    = 17;
    localparam int DW    = 12;
    localparam int DEPTH = 76800;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          wr_valid = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic          wr_drop;
    logic          busy;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    int errors = 0;
    int checks = 0;

    always #20 clk = ~clk;

    fb_port_arbiter dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .wr_drop  (wr_drop),
        .busy     (busy),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    // Behavioural single-port RAM with a bench-side preload port.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_val = '0;

    always @(posedge clk) begin
        if (pl_en)       ram[pl_addr] <= pl_val;
        else if (ram_we) ram[ram_addr] <= ram_din;
        ram_dout <= ram[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: accepted writes queued in order, checked when issued or dropped.
    logic [AW+DW-1:0] exp_q[$];
    logic             rd_pend = 1'b0;
    logic [DW-1:0]    rd_exp = '0;

    always @(negedge clk) begin
        logic [AW+DW-1:0] e;
        if (!reset_n) begin
            exp_q.delete();
            rd_pend = 1'b0;
        end else begin
            if (rd_pend) begin
                check("mon_rd_valid", 32'(rd_valid), 32'd1);
                check("mon_rd_data", 32'(rd_data), 32'(rd_exp));
            end else begin
                check("mon_rd_valid_idle", 32'(rd_valid), 32'd0);
            end
            if (!busy && (ram_we || wr_drop)) begin
                check("mon_sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    if (wr_drop) begin
                        check("mon_drop_oor", 32'(e[AW+DW-1:DW] >= AW'(DEPTH)), 32'd1);
                        check("mon_drop_no_we", 32'(ram_we), 32'd0);
                    end else begin
                        check("mon_wr_addr", 32'(ram_addr), 32'(e[AW+DW-1:DW]));
                        check("mon_wr_data", 32'(ram_din), 32'(e[DW-1:0]));
                    end
                end
            end
            rd_pend = rd_req && !busy;
            rd_exp  = ram[rd_addr];
            if (wr_valid && wr_ready) exp_q.push_back({wr_addr, wr_data});
        end
    end

    typedef struct {
        logic          rd_req;
        logic [AW-1:0] rd_addr;
        logic          wr_valid;
        logic [AW-1:0] wr_addr;
        logic [DW-1:0] wr_data;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic          drop;
        logic          rdv;
        logic [DW-1:0] rdd;
        logic          chk_rdd;
    } vec_t;

    vec_t vecs[10];

    localparam logic BUSY_RST =
`ifdef FB_CLEAR_EN
        1'b1;
`else
        1'b0;
`endif

    initial begin
        #1000000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //                rd  rd_addr   wv  wr_addr      wr_data  we  addr      din     drop rdv rdd     chk
        vecs[0] = '{1'b0, 17'h0,     1'b0, 17'h0,     12'h0,   1'b0, 17'h0,  12'h0,   1'b0, 1'b0, 12'h0,   1'b0};
        vecs[1] = '{1'b0, 17'h0,     1'b1, 17'h10,    12'h123, 1'b0, 17'h0,  12'h0,   1'b0, 1'b0, 12'h0,   1'b0};
        vecs[2] = '{1'b1, 17'h0A0,   1'b0, 17'h0,     12'h0,   1'b0, 17'hA0, 12'h0,   1'b0, 1'b0, 12'h0,   1'b0};
        vecs[3] = '{1'b0, 17'h0,     1'b0, 17'h0,     12'h0,   1'b1, 17'h10, 12'h123, 1'b0, 1'b1, 12'hF0F, 1'b1};
        vecs[4] = '{1'b0, 17'h0,     1'b1, 17'd76800, 12'h555, 1'b0, 17'h0,  12'h0,   1'b0, 1'b0, 12'hF0F, 1'b1};
        vecs[5] = '{1'b0, 17'h0,     1'b0, 17'h0,     12'h0,   1'b0, 17'h0,  12'h0,   1'b1, 1'b0, 12'h0,   1'b0};
        vecs[6] = '{1'b1, 17'h10,    1'b1, 17'h11,    12'h0AB, 1'b0, 17'h10, 12'h0,   1'b0, 1'b0, 12'h0,   1'b0};
        vecs[7] = '{1'b0, 17'h0,     1'b0, 17'h0,     12'h0,   1'b1, 17'h11, 12'h0AB, 1'b0, 1'b1, 12'h123, 1'b1};
        vecs[8] = '{1'b1, 17'h11,    1'b0, 17'h0,     12'h0,   1'b0, 17'h11, 12'h0,   1'b0, 1'b0, 12'h123, 1'b1};
        vecs[9] = '{1'b0, 17'h0,     1'b0, 17'h0,     12'h0,   1'b0, 17'h0,  12'h0,   1'b0, 1'b1, 12'h0AB, 1'b1};

        // Reset state
        #5;
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_wr_drop", 32'(wr_drop), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'(BUSY_RST));
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        #1 check("rel_wr_ready_early", 32'(wr_ready), 32'd0);
        step();
        check("rel_wr_ready", 32'(wr_ready), 32'd1);

`ifdef FB_CLEAR_EN
        begin
            int idx;
            int bad;
            idx = 0;
            bad = 0;
            for (int c = 0; c < 2000; c++) begin
                @(negedge clk);
                if (ram_we && ram_addr == 17'd1000) break;
            end
            check("clr_reached_1000", 32'(ram_addr), 32'd1000);
            #5 reset_n = 1'b0;
            #1 check("clr_rst_we", 32'(ram_we), 32'd0);
            @(posedge clk);
            @(posedge clk);
            #1 reset_n = 1'b1;
            for (int c = 0; c < 80000; c++) begin
                @(negedge clk);
                if (!busy) break;
                if (ram_we) begin
                    if (ram_addr !== AW'(idx) || ram_din !== '0) bad++;
                    idx++;
                end
            end
            check("clr_write_count", 32'(idx), 32'(DEPTH));
            check("clr_bad_writes", 32'(bad), 32'd0);
            check("clr_busy_fall", 32'(busy), 32'd0);
            check("clr_fifo_empty", 32'(ram_we), 32'd0);
            step();
        end
`endif

        // Preload a known pixel for the read-latency vector
        pl_en = 1'b1; pl_addr = 17'h0A0; pl_val = 12'hF0F;
        step();
        pl_en = 1'b0;

        for (int i = 0; i < 10; i++) begin
            rd_req   = vecs[i].rd_req;
            rd_addr  = vecs[i].rd_addr;
            wr_valid = vecs[i].wr_valid;
            wr_addr  = vecs[i].wr_addr;
            wr_data  = vecs[i].wr_data;
            @(negedge clk);
            check($sformatf("vec%0d_ram_we", i), 32'(ram_we), 32'(vecs[i].we));
            check($sformatf("vec%0d_ram_addr", i), 32'(ram_addr), 32'(vecs[i].addr));
            check($sformatf("vec%0d_ram_din", i), 32'(ram_din), 32'(vecs[i].din));
            check($sformatf("vec%0d_wr_drop", i), 32'(wr_drop), 32'(vecs[i].drop));
            check($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'(vecs[i].rdv));
            if (vecs[i].chk_rdd) check($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].rdd));
            step();
        end
        rd_req = 1'b0; wr_valid = 1'b0;
        step();

        // Priority: two queued writes held off by 10 read cycles
        rd_req = 1'b1; rd_addr = 17'h20;
        for (int c = 0; c < 10; c++) begin
            wr_valid = (c < 2);
            wr_addr  = (c == 0) ? 17'h100 : 17'h101;
            wr_data  = (c == 0) ? 12'h1A1 : 12'h2B2;
            @(negedge clk);
            check("prio_no_we", 32'(ram_we), 32'd0);
            step();
        end
        wr_valid = 1'b0; rd_req = 1'b0;
        @(negedge clk);
        check("prio_first_we", 32'(ram_we), 32'd1);
        check("prio_first_addr", 32'(ram_addr), 32'h100);
        step();
        @(negedge clk);
        check("prio_second_addr", 32'(ram_addr), 32'h101);
        check("prio_second_din", 32'(ram_din), 32'h2B2);
        step();
        @(negedge clk);
        check("prio_done", 32'(ram_we), 32'd0);
        step();

        // Backpressure: 5 writes while reads hold the port
        rd_req = 1'b1; wr_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            wr_addr = 17'h200 + AW'(c); wr_data = 12'h300 + DW'(c);
            @(negedge clk);
            check("bp_ready_open", 32'(wr_ready), 32'd1);
            step();
        end
        wr_addr = 17'h204; wr_data = 12'h304;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_ready_full", 32'(wr_ready), 32'd0);
            step();
        end
        rd_req = 1'b0;
        @(negedge clk);
        check("bp_ready_pop_cycle", 32'(wr_ready), 32'd0);
        check("bp_pop_addr", 32'(ram_addr), 32'h200);
        step();
        @(negedge clk);
        check("bp_ready_reopen", 32'(wr_ready), 32'd1);
        step();
        wr_valid = 1'b0;
        repeat (4) step();
        @(negedge clk);
        check("bp_drained", 32'(ram_we), 32'd0);
        step();

        // Range: out-of-range head frees a slot without a RAM write
        rd_req = 1'b1; wr_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            wr_addr = (c == 0) ? AW'(DEPTH) : 17'h3FF + AW'(c);
            wr_data = 12'h700 + DW'(c);
            step();
        end
        wr_valid = 1'b0;
        @(negedge clk);
        check("rng_full", 32'(wr_ready), 32'd0);
        step();
        rd_req = 1'b0;
        @(negedge clk);
        check("rng_drop", 32'(wr_drop), 32'd1);
        check("rng_no_we", 32'(ram_we), 32'd0);
        step();
        rd_req = 1'b1;
        @(negedge clk);
        check("rng_count_dec", 32'(wr_ready), 32'd1);
        check("rng_drop_pulse", 32'(wr_drop), 32'd0);
        step();
        rd_req = 1'b0;
        repeat (4) step();

`ifndef FB_CLEAR_EN
        // Reset in the middle of a drain abandons queued writes
        rd_req = 1'b1; wr_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            wr_addr = 17'h500 + AW'(c); wr_data = 12'h0C0 + DW'(c);
            step();
        end
        rd_req = 1'b0; wr_valid = 1'b0;
        #2 check("drain_we_before_rst", 32'(ram_we), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("drain_rst_we", 32'(ram_we), 32'd0);
        check("drain_rst_rd_valid", 32'(rd_valid), 32'd0);
        check("drain_rst_rd_data", 32'(rd_data), 32'd0);
        check("drain_rst_wr_drop", 32'(wr_drop), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        #1 check("drain_rel_ready_early", 32'(wr_ready), 32'd0);
        step();
        check("drain_rel_ready", 32'(wr_ready), 32'd1);
        check("drain_rel_busy", 32'(busy), 32'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("drain_flushed", 32'(ram_we), 32'd0);
            step();
        end
`endif

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fb_port_arbiter.md
FB_PORT_ARBITER -- requirements
Module: fb_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 17, framebuffer address width.
REQ-002 SHALL have parameter DATA_W, default 12, pixel width (RGB 4:4:4).
REQ-003 SHALL have parameter FB_DEPTH, default 76800, number of valid framebuffer words (320x240).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, write-buffer entries (power of two).
REQ-005 SHALL provide clk  input  1  sole clock (25 MHz pixel domain).
REQ-006 SHALL provide reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL provide rd_req  input  1  scan-out read request this cycle.
REQ-008 SHALL provide rd_addr  input  ADDR_W  scan-out read address.
REQ-009 SHALL provide rd_data  output  DATA_W  read pixel.
REQ-010 SHALL provide rd_valid  output  1  rd_data valid.
REQ-011 SHALL provide wr_valid  input  1  writer offers a pixel.
REQ-012 SHALL provide wr_addr  input  ADDR_W  writer pixel address.
REQ-013 SHALL provide wr_data  input  DATA_W  writer pixel value.
REQ-014 SHALL provide wr_ready  output  1  write buffer can accept.
REQ-015 SHALL provide wr_drop  output  1  one-cycle pulse: out-of-range write discarded.
REQ-016 SHALL provide busy  output  1  framebuffer clear in progress.
REQ-017 SHALL provide ram_we, ram_addr, ram_din  outputs  1/ADDR_W/DATA_W  single-port sync RAM drive.
REQ-018 SHALL provide ram_dout  input  DATA_W  RAM read data, 1-cycle latency.

Function
REQ-019 SHALL implement states CLEAR and RUN; CLEAR -> RUN after address FB_DEPTH-1 is written.
REQ-020 In CLEAR SHALL write 0 to ram_addr = clear counter, incrementing once per cycle from 0; busy=1; rd_req ignored, rd_valid=0.
REQ-021 In RUN, rd_req SHALL have absolute priority: ram_addr=rd_addr, ram_we=0 that cycle.
REQ-022 rd_valid SHALL assert exactly one cycle after an honoured rd_req, rd_data = ram_dout; otherwise rd_valid=0, rd_data holds last value.
REQ-023 Write handshake: entry accepted on cycle wr_valid & wr_ready; wr_ready = FIFO not full (registered count, no same-cycle pop bypass).
REQ-024 In RUN, when rd_req=0 and FIFO non-empty, SHALL pop head and drive ram_we=1, ram_addr/ram_din = head entry.
REQ-025 Head with address >= FB_DEPTH SHALL be popped without RAM write, wr_drop pulsed that cycle.
REQ-026 Simultaneous push and pop SHALL keep count unchanged; FIFO order strictly preserved.
REQ-027 Idle port (no read, no write) SHALL drive ram_we=0, ram_addr=0, ram_din=0.
REQ-028 Writes SHALL be accepted during CLEAR (if not full) and drained only in RUN.

Reset
REQ-029 reset_n low SHALL asynchronously: flush FIFO, clear counter to 0, rd_valid=0, rd_data=0, wr_drop=0, ram_we=0.
REQ-030 Reset release SHALL enter CLEAR (with FB_CLEAR_EN) or RUN (without); wr_ready=1 one cycle after release.
REQ-031 Reset asserted mid-clear or mid-drain SHALL abandon pending work; clear restarts from address 0.

Configuration
REQ-032 Macro FB_CLEAR_EN defined: CLEAR state and counter present as above.
REQ-033 FB_CLEAR_EN undefined: no CLEAR state, busy tied 0, block starts in RUN.

Structure
REQ-034 Shared package fb_pkg SHALL hold FB_ADDR_W, FB_DATA_W, FB_DEPTH constants and the state enum type.
REQ-035 Write buffer SHALL be sub-module fb_wr_fifo (sync FIFO, count, full/empty).

Verification
REQ-036 Clear: reset release with FB_CLEAR_EN -> 76800 writes of 0, addresses 0..76799, busy falls on cycle 76800.
REQ-037 Read latency: RUN, rd_req at addr 0x00A0, RAM holds 0xF0F -> next cycle rd_valid=1, rd_data=0xF0F.
REQ-038 Priority: FIFO holding 2 entries, rd_req held 10 cycles -> no ram_we for 10 cycles, both writes issued in next 2 cycles in order.
REQ-039 Backpressure: 5 back-to-back writes with rd_req held -> wr_ready=0 after 4 accepted, 5th held until pop.
REQ-040 Range: write addr 76800 -> wr_drop pulse, ram_we stays 0, FIFO count decrements.
REQ-041 Mid-clear reset: reset_n low at clear counter 1000 -> after release clear restarts at 0, FIFO empty.
